// File: rtl/ram_portb_scheduler.sv
// ram_portb_scheduler: owns data RAM port B. After reset it optionally sweeps
// every word to CLEAR_VALUE while holding the CPU in reset. It then shares
// port B between r0 (debug host) and r1 (display scanner) using round-robin
// req/gnt arbitration.
// Optional feature macro: RAM_CLEAR_EN. When it is defined, the power-up
// sweep is built. When it is undefined, serving starts on the first clock
// after reset.
module ram_portb_scheduler #(
   parameter int                    DATA_WIDTH         = 16,
   parameter int                    RAM_REGISTER_COUNT = 1024,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE        = 16'h0000,
   localparam int                   AW                 = $clog2(RAM_REGISTER_COUNT)
) (
   input  logic                  Clk,
   input  logic                  Reset,
   output logic                  cpu_hold,
   input  logic                  r0_req,
   input  logic                  r0_we,
   input  logic [AW-1:0]         r0_addr,
   input  logic [DATA_WIDTH-1:0] r0_wdata,
   output logic                  r0_gnt,
   output logic                  r0_rvalid,
   input  logic                  r1_req,
   input  logic                  r1_we,
   input  logic [AW-1:0]         r1_addr,
   input  logic [DATA_WIDTH-1:0] r1_wdata,
   output logic                  r1_gnt,
   output logic                  r1_rvalid,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [AW-1:0]         ram_address_b,
   output logic [DATA_WIDTH-1:0] ram_data_b,
   output logic                  ram_wren_b,
   input  logic [DATA_WIDTH-1:0] ram_q_b
);

   logic                  serve;     // arbitration enabled this cycle
   logic                  in_clear;  // sweep owns port B this cycle
   logic                  rr_last;   // 1: r1 had the most recent grant
   logic [AW-1:0]         hold_addr;
   logic [DATA_WIDTH-1:0] hold_data;

`ifdef RAM_CLEAR_EN
   typedef enum logic {CLEAR, SERVE} state_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_REGISTER_COUNT - 1);

   state_t        state;
   logic [AW-1:0] clr_addr;

   // Sweep sequencer: walk clr_addr up to the last word, then release the CPU.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state    <= CLEAR;
         clr_addr <= '0;
         cpu_hold <= 1'b1;
      end else begin
         case (state)
            CLEAR: begin
               clr_addr <= clr_addr + 1'b1;
               if (clr_addr == LAST_ADDR) begin
                  state    <= SERVE;
                  cpu_hold <= 1'b0;
               end
            end
            default: cpu_hold <= 1'b0;
         endcase
      end
   end

   assign serve    = (state == SERVE);
   assign in_clear = (state == CLEAR) && !Reset;
`else
   // Without a sweep the CPU is released on the first edge after reset.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) cpu_hold <= 1'b1;
      else       cpu_hold <= 1'b0;
   end

   // Grants are gated by cpu_hold so that they start together with the CPU.
   assign serve    = !cpu_hold;
   assign in_clear = 1'b0;
`endif

   // Round-robin grant: a sole requester always wins, and on a tie the
   // requester that was not granted last wins.
   always_comb begin
      r0_gnt = serve && r0_req && (!r1_req ||  rr_last);
      r1_gnt = serve && r1_req && (!r0_req || !rr_last);
   end

   // Port B mux: sweep, then the granted requester, else hold with write off.
   always_comb begin
      ram_address_b = hold_addr;
      ram_data_b    = hold_data;
      ram_wren_b    = 1'b0;
      if (in_clear) begin
         ram_address_b = clr_addr_or_zero();
         ram_data_b    = CLEAR_VALUE;
         ram_wren_b    = 1'b1;
      end else if (r0_gnt) begin
         ram_address_b = r0_addr;
         ram_data_b    = r0_wdata;
         ram_wren_b    = r0_we;
      end else if (r1_gnt) begin
         ram_address_b = r1_addr;
         ram_data_b    = r1_wdata;
         ram_wren_b    = r1_we;
      end
   end

   function automatic logic [AW-1:0] clr_addr_or_zero();
`ifdef RAM_CLEAR_EN
      return clr_addr;
`else
      return '0;
`endif
   endfunction

   // Arbitration history, held port B address/data, and the rvalid pipeline.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rr_last   <= 1'b1;
         hold_addr <= '0;
         hold_data <= CLEAR_VALUE;
         r0_rvalid <= 1'b0;
         r1_rvalid <= 1'b0;
      end else begin
         if (r0_gnt)      rr_last <= 1'b0;
         else if (r1_gnt) rr_last <= 1'b1;
         hold_addr <= ram_address_b;
         hold_data <= ram_data_b;
         r0_rvalid <= r0_gnt && !r0_we;
         r1_rvalid <= r1_gnt && !r1_we;
      end
   end

   // The RAM output register already provides the one-cycle read latency.
   assign rdata = ram_q_b;

endmodule

// File: tb/tb_ram_portb_scheduler.sv
// Directed bench for ram_portb_scheduler. Expectations follow whichever
// build is compiled (RAM_CLEAR_EN defined or not).
module tb_ram_portb_scheduler;
   localparam int DW = 16;
   localparam int N  = 1024;
   localparam int AW = 10;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          cpu_hold;
   logic          r0_req, r0_we, r0_gnt, r0_rvalid;
   logic [AW-1:0] r0_addr;
   logic [DW-1:0] r0_wdata;
   logic          r1_req, r1_we, r1_gnt, r1_rvalid;
   logic [AW-1:0] r1_addr;
   logic [DW-1:0] r1_wdata;
   logic [DW-1:0] rdata;
   logic [AW-1:0] ram_address_b;
   logic [DW-1:0] ram_data_b;
   logic          ram_wren_b;
   logic [DW-1:0] ram_q_b;

   int compared   = 0;
   int mismatched = 0;

   always #5 Clk = ~Clk;

   ram_portb_scheduler #(
      .DATA_WIDTH(DW),
      .RAM_REGISTER_COUNT(N),
      .CLEAR_VALUE(16'h0000)
   ) dut (
      .Clk(Clk), .Reset(Reset), .cpu_hold(cpu_hold),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
      .rdata(rdata),
      .ram_address_b(ram_address_b), .ram_data_b(ram_data_b),
      .ram_wren_b(ram_wren_b), .ram_q_b(ram_q_b)
   );

   // Port B RAM model: synchronous write, registered read.
   logic [DW-1:0] mem [0:N-1];
   always @(posedge Clk) begin
      if (ram_wren_b) mem[ram_address_b] <= ram_data_b;
      ram_q_b <= mem[ram_address_b];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
      r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
   endtask

`ifdef RAM_CLEAR_EN
   task automatic sweep(input int n, input bit r1_at10);
      for (int i = 0; i < n; i++) begin
         if (r1_at10 && i == 10) begin
            r1_req = 1'b1; r1_we = 1'b0; r1_addr = 10'h3FF;
         end
         #1;
         chk("sweep_hold", cpu_hold, 1);
         chk("sweep_wren", ram_wren_b, 1);
         chk("sweep_addr", ram_address_b, i);
         chk("sweep_data", ram_data_b, 0);
         chk("sweep_gnt", {r0_gnt, r1_gnt}, 0);
         cyc();
      end
   endtask
`endif

   initial begin
      logic e0, e1;
      Reset = 1'b1;
      idle();
      r0_req = 1'b1; r0_we = 1'b1; r0_addr = 10'd5; r0_wdata = 16'hBEEF;
      repeat (2) cyc();
      #1;
      chk("rst_hold",   cpu_hold, 1);
      chk("rst_gnt",    {r0_gnt, r1_gnt}, 0);
      chk("rst_rvalid", {r0_rvalid, r1_rvalid}, 0);
      chk("rst_wren",   ram_wren_b, 0);
      chk("rst_addr",   ram_address_b, 0);
      chk("rst_data",   ram_data_b, 0);

`ifdef RAM_CLEAR_EN
      r0_req = 1'b0;
      Reset  = 1'b0;
      sweep(N, 1'b1);
      #1;
      chk("serve0_hold", cpu_hold, 0);
      chk("serve0_r1gnt", r1_gnt, 1);
      chk("serve0_r0gnt", r0_gnt, 0);
      chk("serve0_wren", ram_wren_b, 0);
      chk("serve0_addr", ram_address_b, 10'h3FF);
      cyc();
      r1_req = 1'b0;
      r0_req = 1'b1;
      #1;
      chk("r1_rd_rvalid", r1_rvalid, 1);
      chk("r1_rd_rdata", rdata, 16'h0000);
      chk("r0_wr_gnt", r0_gnt, 1);
      chk("r0_wr_wren", ram_wren_b, 1);
      chk("r0_wr_addr", ram_address_b, 5);
      chk("r0_wr_data", ram_data_b, 16'hBEEF);
      chk("r0_wr_rvalid", r0_rvalid, 0);
`else
      Reset = 1'b0;
      #1;
      chk("rel_hold", cpu_hold, 1);
      chk("rel_gnt", r0_gnt, 0);
      chk("rel_wren", ram_wren_b, 0);
      cyc();
      #1;
      chk("first_hold", cpu_hold, 0);
      chk("r0_wr_gnt", r0_gnt, 1);
      chk("r0_wr_wren", ram_wren_b, 1);
      chk("r0_wr_addr", ram_address_b, 5);
      chk("r0_wr_data", ram_data_b, 16'hBEEF);
      chk("r0_wr_rvalid", r0_rvalid, 0);
`endif

      // r0 reads back the word it just wrote
      cyc();
      r0_we = 1'b0;
      #1;
      chk("r0_rd_gnt", r0_gnt, 1);
      chk("r0_rd_wren", ram_wren_b, 0);
      chk("r0_rd_addr", ram_address_b, 5);
      chk("wr_no_rvalid", r0_rvalid, 0);
      cyc();
      r0_req = 1'b0;
      r1_req = 1'b1; r1_we = 1'b1; r1_addr = 10'd9; r1_wdata = 16'h1234;
      #1;
      chk("r0_rvalid", r0_rvalid, 1);
      chk("r0_rdata", rdata, 16'hBEEF);
      chk("r1_rvalid_q", r1_rvalid, 0);
      chk("r1_wr9_gnt", {r0_gnt, r1_gnt}, 2'b01);
      chk("r1_wr9_wren", ram_wren_b, 1);
      chk("r1_wr9_addr", ram_address_b, 9);
      chk("r1_wr9_data", ram_data_b, 16'h1234);

      // back-to-back uncontended write from r1
      cyc();
      r1_addr = 10'd10; r1_wdata = 16'h5678;
      #1;
      chk("r1_wr10_gnt", r1_gnt, 1);
      chk("r1_wr10_addr", ram_address_b, 10);
      chk("r1_wr10_data", ram_data_b, 16'h5678);
      chk("r1_wr10_rvalid", {r0_rvalid, r1_rvalid}, 0);

      // no request: write off, address and data held
      cyc();
      r1_req = 1'b0;
      #1;
      chk("idle_gnt", {r0_gnt, r1_gnt}, 0);
      chk("idle_wren", ram_wren_b, 0);
      chk("idle_addr", ram_address_b, 10);
      chk("idle_data", ram_data_b, 16'h5678);

      // both read continuously: r0 first since r1 was granted last
      cyc();
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = 10'd5;
      r1_req = 1'b1; r1_we = 1'b0; r1_addr = 10'd9;
      for (int k = 0; k < 6; k++) begin
         e0 = (k % 2 == 0);
         e1 = !e0;
         #1;
         chk("rr_g0", r0_gnt, e0);
         chk("rr_g1", r1_gnt, e1);
         chk("rr_addr", ram_address_b, e0 ? 5 : 9);
         chk("rr_wren", ram_wren_b, 0);
         chk("rr_rv0", r0_rvalid, (k > 0) && e1);
         chk("rr_rv1", r1_rvalid, (k > 0) && e0);
         if (k > 0) chk("rr_rdata", rdata, e1 ? 16'hBEEF : 16'h1234);
         cyc();
      end
      idle();
      #1;
      chk("rr_last_rv1", r1_rvalid, 1);
      chk("rr_last_rv0", r0_rvalid, 0);
      chk("rr_last_rdata", rdata, 16'h1234);

      // reset with a read in flight drops its rvalid
      cyc();
      r0_req = 1'b1; r0_addr = 10'd5;
      #1;
      chk("fl_gnt", r0_gnt, 1);
      cyc();
      r0_req = 1'b0;
      #1;
      chk("fl_rvalid", r0_rvalid, 1);
      Reset = 1'b1;
      #1;
      chk("mid_rst_rvalid", r0_rvalid, 0);
      chk("mid_rst_hold", cpu_hold, 1);
      chk("mid_rst_wren", ram_wren_b, 0);
      chk("mid_rst_addr", ram_address_b, 0);
      chk("mid_rst_data", ram_data_b, 0);
      cyc();
      Reset = 1'b0;

`ifdef RAM_CLEAR_EN
      // reset part-way through the sweep restarts it from address 0
      sweep(300, 1'b0);
      #1;
      chk("part_addr", ram_address_b, 300);
      Reset = 1'b1;
      #1;
      chk("part_rst_hold", cpu_hold, 1);
      chk("part_rst_wren", ram_wren_b, 0);
      chk("part_rst_addr", ram_address_b, 0);
      cyc();
      Reset = 1'b0;
      sweep(N, 1'b0);
      #1;
      chk("resweep_hold", cpu_hold, 0);
      chk("resweep_wren", ram_wren_b, 0);
`else
      #1;
      chk("rerel_hold", cpu_hold, 1);
      cyc();
      #1;
      chk("rerel_hold_low", cpu_hold, 0);
      chk("rerel_gnt", {r0_gnt, r1_gnt}, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/ram_portb_scheduler.md
Name: ram_portb_scheduler

Overview:
- Owns the data RAM's second port (port B), which the CPU never uses.
- After reset it optionally sweeps the whole RAM to a clear value, holding the CPU in reset (cpu_hold) until the sweep is done.
- It then shares port B between two requesters, r0 (debug host) and r1 (display scanner), using round-robin arbitration with a req/gnt handshake.

Parameters:
- DATA_WIDTH, 16, RAM word width in bits.
- RAM_REGISTER_COUNT, 1024, number of RAM words. Derived: AW = $clog2(RAM_REGISTER_COUNT).
- CLEAR_VALUE, 16'h0000, word written to every address during the sweep.

Ports:
- Clk  in  1  single clock; RAM port B is clocked by the same Clk.
- Reset  in  1  asynchronous, active-high reset.
- cpu_hold  out  1  high while the CPU must stay in reset.
- r0_req  in  1  request valid.
- r0_we  in  1  1 = write, 0 = read.
- r0_addr  in  AW  word address.
- r0_wdata  in  DATA_WIDTH  write data.
- r0_gnt  out  1  request accepted this cycle.
- r0_rvalid  out  1  read data valid on rdata.
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid: same as r0.
- rdata  out  DATA_WIDTH  shared read data; meaningful only when an rvalid is high.
- ram_address_b  out  AW  to RAM address_b.
- ram_data_b  out  DATA_WIDTH  to RAM data_b.
- ram_wren_b  out  1  to RAM wren_b.
- ram_q_b  in  DATA_WIDTH  from RAM q_b (registered, 1-cycle read latency).

Behaviour:
- States: CLEAR, SERVE. Reset forces state = CLEAR, clr_addr = 0, rr_last = r1 (so r0 wins first), rvalid pipeline = 0.
- Outputs while Reset is high:
  - cpu_hold = 1.
  - r0_gnt = r1_gnt = r0_rvalid = r1_rvalid = 0.
  - ram_wren_b = 0, ram_address_b = 0, ram_data_b = CLEAR_VALUE.
- CLEAR (Reset low):
  - ram_address_b = clr_addr, ram_data_b = CLEAR_VALUE, ram_wren_b = 1.
  - clr_addr increments by 1 each cycle.
  - The write to address RAM_REGISTER_COUNT-1 is the last one; the next state is SERVE. The sweep takes exactly RAM_REGISTER_COUNT cycles.
  - No grants are issued. cpu_hold = 1.
- SERVE:
  - cpu_hold = 0, registered, so it falls in the first SERVE cycle.
  - Grants are combinational from req and state; at most one gnt per cycle.
  - Only one requester asserting req: it is granted.
  - Both asserting req: the one not equal to rr_last is granted. rr_last updates on every grant.
  - Granted requester's addr, wdata and we drive ram_address_b, ram_data_b and ram_wren_b in the same cycle.
  - No grant: ram_wren_b = 0; address and data hold their last values. ram_wren_b is never high without a grant or a sweep.
- Handshake:
  - A transaction completes on the cycle where req && gnt.
  - The requester keeps req, we, addr and wdata stable until gnt.
  - Back-to-back transactions from the same requester are allowed, one per cycle, when uncontended.
- Read return:
  - A read granted in cycle N asserts that requester's rvalid in cycle N+1, with rdata = ram_q_b (passthrough).
  - Writes produce no rvalid.
  - The rvalid pipeline is one registered bit per requester.
- Reset mid-operation (during CLEAR or SERVE):
  - All state returns to reset values immediately (asynchronous).
  - The sweep restarts from address 0 on release.
  - An in-flight rvalid is dropped.
- clr_addr is sized AW bits. The terminal compare is against RAM_REGISTER_COUNT-1, so a non-power-of-2 count stops early and never wraps.

Optional Feature:
- RAM_CLEAR_EN defined:
  - Sweep is performed as described.
- RAM_CLEAR_EN undefined:
  - CLEAR state and clr_addr are not built.
  - Reset forces SERVE directly, with cpu_hold = 1 during Reset.
  - cpu_hold = 0 from the first clock edge after Reset deasserts.
  - Requests are granted from that same cycle.

Test Plan:
- RAM_CLEAR_EN, release Reset → cpu_hold stays 1 for 1024 cycles; ram_wren_b = 1 with addresses 0..1023 in order and data 0x0000; then cpu_hold = 0 and ram_wren_b = 0.
- After clear:
  - r0 writes addr 5 = 0xBEEF → r0_gnt same cycle, no rvalid.
  - r0 then reads addr 5 → r0_rvalid = 1 next cycle with rdata = 0xBEEF; r1_rvalid stays 0.
- r0 and r1 both hold read requests for 6 cycles → grant order r0, r1, r0, r1, r0, r1; each rvalid follows its grant by 1 cycle.
- r1_req asserted (addr 0x3FF, read) at clear cycle 10 → no r1_gnt until the first SERVE cycle, then granted; rdata = 0x0000.
- Reset asserted when clr_addr = 300 → cpu_hold = 1 and ram_wren_b = 0 immediately; after release the sweep restarts at address 0 and lasts a full 1024 cycles.
- RAM_CLEAR_EN undefined, release Reset with r0_req held (write) → cpu_hold = 0 and r0_gnt = 1 on the first cycle after release.
